// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC generation, imem request issue and a 2-entry prefetch queue feeding IF/ID.
// Optional macro FETCH_PERF_EN adds a saturating stall-cycle counter on stall_cnt.
module if_fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INS   = 16'h0000,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] pc_out,
  output logic [15:0] ins_out,
  output logic        valid_out,
  output logic [15:0] stall_cnt
);
  localparam logic [1:0] LP_MAX_OUTST = 2'(MAX_OUTST);

  logic [15:0] r_fetch_pc;
  logic [1:0]  r_outst;
  logic [1:0]  r_drop_cnt;
  logic [15:0] r_tag [2];
  logic        r_tag_rd;
  logic        r_tag_wr;
  logic [15:0] r_q_pc [2];
  logic [15:0] r_q_ins [2];
  logic        r_q_rd;
  logic        r_q_wr;
  logic [1:0]  r_q_count;

  logic        w_accept;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic [2:0]  w_occupancy;
  logic [1:0]  w_outst_after_resp;

  assign valid_out = (r_q_count != 2'd0);
  assign pc_out    = valid_out ? r_q_pc[r_q_rd]  : 16'h0000;
  assign ins_out   = valid_out ? r_q_ins[r_q_rd] : NOP_INS;

  assign w_pop  = valid_out && !stall_in && !redirect_in;
  assign w_drop = imem_rvalid && (redirect_in || (r_drop_cnt != 2'd0));
  assign w_push = imem_rvalid && !w_drop;

  // The head leaving this cycle frees its slot, so a ready memory sustains one word per cycle.
  assign w_occupancy = 3'(r_q_count) + 3'(r_outst) - 3'(w_pop);
  assign imem_req    = reset_n && !redirect_in && (w_occupancy < 3'd2) &&
                       (r_outst < LP_MAX_OUTST);
  assign imem_addr   = r_fetch_pc;
  assign w_accept    = imem_req && imem_ready;

  assign w_outst_after_resp = r_outst - 2'(imem_rvalid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc <= RESET_PC;
      r_outst    <= 2'd0;
      r_drop_cnt <= 2'd0;
    end else if (redirect_in) begin
      // Everything still in flight belongs to the old path and must be discarded.
      r_fetch_pc <= redirect_pc;
      r_outst    <= w_outst_after_resp;
      r_drop_cnt <= w_outst_after_resp;
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 16'd1;
      end
      r_outst <= w_outst_after_resp + 2'(w_accept);
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag[0] <= 16'h0000;
      r_tag[1] <= 16'h0000;
      r_tag_rd <= 1'b0;
      r_tag_wr <= 1'b0;
    end else if (redirect_in) begin
      r_tag_rd <= 1'b0;
      r_tag_wr <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tag[r_tag_wr] <= r_fetch_pc;
        r_tag_wr        <= !r_tag_wr;
      end
      if (w_push) begin
        r_tag_rd <= !r_tag_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q_pc[0]  <= 16'h0000;
      r_q_pc[1]  <= 16'h0000;
      r_q_ins[0] <= 16'h0000;
      r_q_ins[1] <= 16'h0000;
      r_q_rd     <= 1'b0;
      r_q_wr     <= 1'b0;
      r_q_count  <= 2'd0;
    end else if (redirect_in) begin
      r_q_rd    <= 1'b0;
      r_q_wr    <= 1'b0;
      r_q_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_q_pc[r_q_wr]  <= r_tag[r_tag_rd];
        r_q_ins[r_q_wr] <= imem_rdata;
        r_q_wr          <= !r_q_wr;
      end
      if (w_pop) begin
        r_q_rd <= !r_q_rd;
      end
      r_q_count <= r_q_count + 2'(w_push) - 2'(w_pop);
    end
  end

  // The issue rule reserves a slot for every outstanding word; overflow means a protocol break.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(w_push && !w_pop && (r_q_count == 2'd2)));
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= 16'h0000;
    end else if (stall_in && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
